// File: rtl/uart_rx_fifo_pkg.sv
// Shared receive-path types: FSM state encoding, parity modes and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Expected parity bit for a payload zero-extended to 9 bits.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head is visible on dout whenever empty=0.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rptr];

    // NOTE: storage is not reset; every entry is written before the read pointer can reach it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with false-start rejection, optional parity, sticky error flags and an
// integrated FWFT FIFO toward the CPU.
module uart_rx_fifo #(
    parameter int CLK_PER_HALF_BIT = 86,
    parameter int DATA_BITS        = 8,
    parameter int DEPTH_LOG2       = 4,
    parameter int PARITY           = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_BITS-1:0]  dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  busy,
    output logic                  overrun,
    output logic                  frame_err,
    output logic                  parity_err
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(2 * CLK_PER_HALF_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic [1:0]           sync_vld;
    logic                 armed;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bad;
    logic                 expire;
    logic                 push;
    logic                 frame_evt;
    logic                 parity_evt;
    logic                 overrun_evt;

    assign expire = (cnt == '0);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            sync_vld <= 2'b00;
        end else begin
            rx_meta  <= rxd;
            rx_s     <= rx_meta;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    // Arm only on a genuine high line sample, so a line held low through reset is not a start.
    always_ff @(posedge clk) begin
        if (rst)                     armed <= 1'b0;
        else if (sync_vld[1] && rx_s) armed <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_bad   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (armed && !rx_s) begin
                        cnt   <= HALF_LOAD;
                        state <= START;
                    end
                end
                START: begin
                    if (!expire) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_s) begin
                        state <= IDLE;
                    end else begin
                        cnt     <= FULL_LOAD;
                        bit_idx <= '0;
                        par_bad <= 1'b0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (!expire) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift_reg[bit_idx] <= rx_s;
                        bit_idx            <= bit_idx + 1'b1;
                        cnt                <= FULL_LOAD;
                        if (bit_idx == LAST_IDX)
                            state <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                    end
                end
                uart_pkg::PARITY: begin
                    if (!expire) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        par_bad <= (rx_s != parity_bit(9'(shift_reg), PARITY));
                        cnt     <= FULL_LOAD;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (!expire) cnt <= cnt - 1'b1;
                    else         state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        frame_evt   = 1'b0;
        parity_evt  = 1'b0;
        overrun_evt = 1'b0;
        push        = 1'b0;
        if (state == STOP && expire) begin
            if (!rx_s)              frame_evt   = 1'b1;
            else if (par_bad)       parity_evt  = 1'b1;
            else if (full && !rd_en) overrun_evt = 1'b1;
            else                    push        = 1'b1;
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (overrun_evt)  overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (frame_evt)    frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (parity_evt)   parity_err <= 1'b1;
            else if (clr_err) parity_err <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH      (DATA_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd_en),
        .din   (shift_reg),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .count (count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized frames against a queue model.
module tb_uart_rx_fifo;

    localparam int H     = 4;
    localparam int DB    = 8;
    localparam int DL    = 2;
    localparam int DEPTH = 4;
    localparam int BIT   = 2 * H;

    logic       clk = 1'b0;
    logic       rst, clr_err;
    logic       rxd, rd_en;
    logic [7:0] dout;
    logic       empty, full, busy, overrun, frame_err, parity_err;
    logic [2:0] count;
    logic       p_rxd, p_rd_en;
    logic [7:0] p_dout;
    logic       p_empty, p_full, p_busy, p_overrun, p_frame_err, p_parity_err;
    logic [2:0] p_count;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_PER_HALF_BIT(H), .DATA_BITS(DB), .DEPTH_LOG2(DL), .PARITY(0)) u_dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rd_en(rd_en), .clr_err(clr_err),
        .dout(dout), .empty(empty), .full(full), .count(count), .busy(busy),
        .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err));

    uart_rx_fifo #(.CLK_PER_HALF_BIT(H), .DATA_BITS(DB), .DEPTH_LOG2(DL), .PARITY(2)) u_dut_par (
        .clk(clk), .rst(rst), .rxd(p_rxd), .rd_en(p_rd_en), .clr_err(clr_err),
        .dout(p_dout), .empty(p_empty), .full(p_full), .count(p_count), .busy(p_busy),
        .overrun(p_overrun), .frame_err(p_frame_err), .parity_err(p_parity_err));

    int cyc = 0;
    int fall_cyc = -1;
    logic empty_q = 1'b1;
    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    bit m_ovr = 1'b0;
    bit m_fe  = 1'b0;
    bit m_pe  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (empty_q && !empty) fall_cyc = cyc;
        empty_q = empty;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input bit to_par, input logic b, input int cycles);
        if (to_par) p_rxd = b;
        else        rxd   = b;
        repeat (cycles) @(negedge clk);
    endtask

    // Start, LSB-first data, optional even-parity bit, stop, then idle line.
    task automatic send_frame(input bit to_par, input logic [7:0] d, input bit bad_stop, input bit bad_par);
        logic pb;
        drive_bit(to_par, 1'b0, BIT);
        for (int i = 0; i < DB; i++) drive_bit(to_par, d[i], BIT);
        if (to_par) begin
            pb = (($countones(d) % 2) == 1) ^ bad_par;
            drive_bit(1'b1, pb, BIT);
        end
        drive_bit(to_par, !bad_stop, BIT);
        drive_bit(to_par, 1'b1, 4 * BIT);
    endtask

    task automatic model_frame(input logic [7:0] d, input bit bad_stop, input bit pop_at_stop);
        if (pop_at_stop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (bad_stop)                  m_fe = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else                           m_ovr = 1'b1;
    endtask

    task automatic check_main(input string tag);
        check({tag, "_count"}, count, exp_q.size());
        check({tag, "_empty"}, empty, exp_q.size() == 0);
        check({tag, "_full"},  full,  exp_q.size() == DEPTH);
        if (exp_q.size() > 0) check({tag, "_dout"}, dout, exp_q[0]);
        check({tag, "_overrun"},    overrun,    m_ovr);
        check({tag, "_frame_err"},  frame_err,  m_fe);
        check({tag, "_parity_err"}, parity_err, 1'b0);
        check({tag, "_busy"},       busy,       1'b0);
    endtask

    task automatic pop_main();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ovr = 1'b0;
        m_fe  = 1'b0;
    endtask

    initial begin
        int s;
        logic [7:0] d;
        bit bs, bp;
        rst = 1'b1; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0; p_rxd = 1'b1; p_rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dout", dout, 8'h00);
        check_main("reset");
        rst = 1'b0;
        repeat (BIT) @(negedge clk);

        // Single 8N1 frame; empty must fall exactly one cycle after the stop mid-sample.
        s = cyc;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0);
        model_frame(8'hA5, 1'b0, 1'b0);
        check("t1_empty_fall_cycle", fall_cyc, s + 3 + H + 2 * H * (DB + 1));
        check_main("t1");
        pop_main();
        check_main("t1_pop");

        // Short low glitch must be rejected at the start-bit midpoint.
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        check("t2_busy_during_glitch", busy, 1'b1);
        repeat (4 * BIT) @(negedge clk);
        check_main("t2");

        // Overflow a depth-4 FIFO with five frames.
        for (int i = 1; i <= 5; i++) begin
            send_frame(1'b0, 8'(i), 1'b0, 1'b0);
            model_frame(8'(i), 1'b0, 1'b0);
        end
        check_main("t3_full");
        for (int i = 0; i < DEPTH; i++) begin
            check("t3_pop_dout", dout, 8'(i + 1));
            pop_main();
        end
        check_main("t3_drained");
        clear_err();
        check_main("t3_clr");

        // Framing error discards the byte; the next good frame is accepted.
        send_frame(1'b0, 8'h3C, 1'b1, 1'b0);
        model_frame(8'h3C, 1'b1, 1'b0);
        check_main("t4_bad_stop");
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0);
        check_main("t4_good");
        clear_err();
        pop_main();
        check_main("t4_clean");

        // Pop in the exact stop-sample cycle of a frame arriving into a full FIFO.
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(1'b0, 8'h11 + 8'(i), 1'b0, 1'b0);
            model_frame(8'h11 + 8'(i), 1'b0, 1'b0);
        end
        check_main("t6_prefill");
        s = 3 + H + 2 * H * (DB + 1);
        fork
            send_frame(1'b0, 8'h55, 1'b0, 1'b0);
            begin
                repeat (s - 1) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        model_frame(8'h55, 1'b0, 1'b1);
        check_main("t6_pop_at_stop");
        for (int i = 0; i < DEPTH - 1; i++) pop_main();
        check("t6_last_is_55", dout, 8'h55);
        pop_main();
        check_main("t6_drained");

        // Randomized frames, framing errors, reads and error clears.
        for (int it = 0; it < 40; it++) begin
            d  = 8'($urandom);
            bs = ($urandom_range(0, 5) == 0);
            for (int k = $urandom_range(0, 2); k > 0; k--) pop_main();
            if ($urandom_range(0, 7) == 0) clear_err();
            send_frame(1'b0, d, bs, 1'b0);
            model_frame(d, bs, 1'b0);
            check_main("rand");
        end

        // Reset in the middle of a frame with the line held low afterwards.
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        check("rst_dout", dout, 8'h00);
        check_main("rst_mid");
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        check("rst_low_line_busy", busy, 1'b0);
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
        send_frame(1'b0, 8'h96, 1'b0, 1'b0);
        model_frame(8'h96, 1'b0, 1'b0);
        check_main("rst_recover");

        // Even-parity instance: bad parity dropped, good parity accepted.
        send_frame(1'b1, 8'h07, 1'b0, 1'b1);
        check("t5_parity_err", p_parity_err, 1'b1);
        check("t5_bad_empty",  p_empty,      1'b1);
        check("t5_frame_err",  p_frame_err,  1'b0);
        send_frame(1'b1, 8'h07, 1'b0, 1'b0);
        check("t5_good_dout",  p_dout,  8'h07);
        check("t5_good_count", p_count, 3'd1);
        p_rd_en = 1'b1; @(negedge clk); p_rd_en = 1'b0;
        m_pe = 1'b1;
        for (int it = 0; it < 8; it++) begin
            d  = 8'($urandom);
            bp = ($urandom_range(0, 2) == 0);
            send_frame(1'b1, d, 1'b0, bp);
            if (bp) m_pe = 1'b1;
            check("par_rand_err",   p_parity_err, m_pe);
            check("par_rand_empty", p_empty,      bp);
            if (!bp) begin
                check("par_rand_dout", p_dout, d);
                p_rd_en = 1'b1; @(negedge clk); p_rd_en = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
